coolgirl_config_ctrl: RTL and testbench
=======================================

# coolgirl_config_ctrl

Boot-time configuration controller for the multicart. Decodes CPU writes to $5000-$5FFF into shadow copies of the banking and memory-control fields: PRG base and mask, CHR mask, mapper select, SRAM page and enable bits, write enables, ROM-at-$6000 and four-screen. Shadow values are committed atomically to the active outputs when the CPU next fetches from cartridge ROM, so the menu loader can switch banks from code in RAM. After commit, an optional sticky lock freezes the configuration until reset.

## Interface

Parameters:
- `MAPPER_BITS`, 5: width of the mapper-select field.
- `COMMIT_TIMEOUT`, 255: cycles an armed commit waits for a ROM access before it is forced; range 1-255.

Ports:
- `m2`, input, 1: CPU M2, the only clock; all state changes on its rising edge.
- `reset`, input, 1: synchronous, active-high.
- `romsel`, input, 1: CPU /ROMSEL; low means a $8000-$FFFF access.
- `cpu_rw_in`, input, 1: 1 = read, 0 = write.
- `cpu_addr_in`, input, 15: CPU A14..A0.
- `cpu_data_in`, input, 8: CPU data; stable at the sampling edge.
- `cpu_base`, output, 13: active PRG base, bits [26:14].
- `prg_mask`, output, 7: active PRG mask, bits [20:14].
- `chr_mask`, output, 5: active CHR mask, bits [17:13].
- `mapper`, output, MAPPER_BITS: active mapper select.
- `sram_page`, output, 2: active SRAM page.
- `sram_enabled`, `chr_write_enabled`, `prg_write_enabled`, `map_rom_on_6000`, `four_screen`, output, 1 each: active control bits.
- `locked`, output, 1: configuration frozen.
- `commit_pending`, output, 1: a commit is armed and not yet applied.
- `cpu_data_out`, output, 8: readback data. Present only with `COOLGIRL_CFG_READBACK_EN`.
- `cpu_data_out_enabled`, output, 1: readback drive enable. Present only with `COOLGIRL_CFG_READBACK_EN`.

## Operation

- **Register write**: `romsel`=1, `cpu_rw_in`=0, `cpu_addr_in[14:12]`=3'b101, `locked`=0. `cpu_addr_in[2:0]` selects the register:
  - 0: shadow base[26:22] <= d[4:0]
  - 1: shadow base[21:14] <= d[7:0]
  - 2: shadow prg_mask <= d[6:0]
  - 3: shadow chr_mask <= d[4:0]
  - 4: shadow mapper <= d[MAPPER_BITS-1:0]
  - 5: shadow {four_screen, map_rom_on_6000, prg_write_enabled, chr_write_enabled, sram_enabled, sram_page} <= d[6:0]
  - 6: control. d[0]=1 arms a commit. d[7]=1 requests lock.
  - 7: no effect.
- **States**:
  - IDLE -> ARMED on a control write with d[0]=1. The timeout counter loads `COMMIT_TIMEOUT`.
  - ARMED -> IDLE on an edge with `romsel`=0, or on the edge where the counter reaches 0. On that edge, active registers <= shadow.
  - While ARMED the counter decrements every edge. Shadow writes remain legal; the applied value is the shadow content at the apply edge.
  - ARMED plus another commit write: counter reloads and state stays ARMED.
- **Lock**:
  - A lock request sets `lock_req`.
  - `locked` rises on the apply edge if `lock_req`, or immediately if state is IDLE and no commit is armed in the same write.
  - Once `locked`=1, all $5xxx writes are ignored, including control writes. It stays set until `reset`.
  - d[0]=1 and d[7]=1 in one write: arm, then commit and lock together at apply.
- **Same-edge collision**: a shadow write on the apply edge lands in the shadow only; the active registers take the pre-write shadow.
- **Reset values**:
  - Active and shadow: base=0, prg_mask=7'h7E, chr_mask=0, mapper=0, sram_page=0, all control bits 0.
  - State IDLE, counter 0, `lock_req`=0, `locked`=0, `commit_pending`=0.
  - `cpu_data_out`=0 and `cpu_data_out_enabled`=0 (readback builds).
- **Reset mid-operation**: reset while ARMED discards the armed commit and returns every field to its reset value.
- **Arithmetic**: the counter is 8 bits, unsigned, and never wraps; decrement stops at 0.

## Timing

- Shadow register updated at the write edge and readable the next cycle.
- Commit write at edge k gives `commit_pending`=1 from k.
- Earliest apply is edge k+1, if `romsel`=0 there. Latest apply is edge k+`COMMIT_TIMEOUT`.
- Active outputs and `commit_pending` change on the apply edge, zero extra latency.
- `locked` is registered and changes only on a rising edge of `m2`.

## Configuration

- `COOLGIRL_CFG_READBACK_EN` defined:
  - A read with `romsel`=1, `cpu_rw_in`=1 and A14..12=101 drives `cpu_data_out_enabled`=1 combinationally.
  - `cpu_data_out` gives the shadow register selected by A[2:0], zero-extended.
  - Register 6 reads {locked, 6'b0, commit_pending}. Register 7 reads 8'h00.
- Undefined: readback ports and logic are absent, and the block never drives the bus.

## Test plan

- Reset, then sample outputs -> cpu_base=0, prg_mask=7'h7E, mapper=0, locked=0, commit_pending=0.
- Write $5001=8'h2A, $5004=8'h04, $5006=8'h01, then one cycle with romsel=1, then romsel=0 -> outputs unchanged until the romsel=0 edge; then cpu_base[21:14]=8'h2A, mapper=4, commit_pending=0.
- COMMIT_TIMEOUT=4, arm commit, hold romsel=1 -> apply on exactly the 4th edge after the commit write.
- Write $5006=8'h81, apply, then write $5004=8'h07 and $5006=8'h01 -> locked=1 and mapper unchanged at its committed value.
- Arm commit, assert reset on the next edge, then romsel=0 -> no apply; all fields at reset values.
- (READBACK) Write $5003=8'h1F, read $5003 -> cpu_data_out=8'h1F and cpu_data_out_enabled=1. Read $5007 -> 8'h00.

Source files
------------

// File: rtl/coolgirl_config_ctrl.sv
// ============================================================================
// Module   : coolgirl_config_ctrl
// Purpose  : $5000-$5FFF configuration shadow registers with atomic commit on
//            the next cartridge ROM fetch (or timeout), plus sticky lock.
//            Optional readback when COOLGIRL_CFG_READBACK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module coolgirl_config_ctrl #(
    parameter int MAPPER_BITS    = 5,
    parameter int COMMIT_TIMEOUT = 255
) (
    input  logic                   m2,
    input  logic                   reset,
    input  logic                   romsel,
    input  logic                   cpu_rw_in,
    input  logic [14:0]            cpu_addr_in,
    input  logic [7:0]             cpu_data_in,
    output logic [12:0]            cpu_base,
    output logic [6:0]             prg_mask,
    output logic [4:0]             chr_mask,
    output logic [MAPPER_BITS-1:0] mapper,
    output logic [1:0]             sram_page,
    output logic                   sram_enabled,
    output logic                   chr_write_enabled,
    output logic                   prg_write_enabled,
    output logic                   map_rom_on_6000,
    output logic                   four_screen,
    output logic                   locked,
    output logic                   commit_pending
`ifdef COOLGIRL_CFG_READBACK_EN
    ,
    output logic [7:0]             cpu_data_out,
    output logic                   cpu_data_out_enabled
`endif
);

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_armed = 1'b1;
    localparam logic [7:0] c_timeout  = COMMIT_TIMEOUT[7:0];
    localparam logic [6:0] c_prg_mask_rst = 7'h7E;

    logic [0:0]             r_state;
    logic [7:0]             r_count;
    logic                   r_lock_req;
    logic                   r_locked;

    logic [12:0]            r_sh_base,     r_act_base;
    logic [6:0]             r_sh_prg_mask, r_act_prg_mask;
    logic [4:0]             r_sh_chr_mask, r_act_chr_mask;
    logic [MAPPER_BITS-1:0] r_sh_mapper,   r_act_mapper;
    logic [6:0]             r_sh_ctrl,     r_act_ctrl;

    logic       w_sel;
    logic       w_wr;
    logic [2:0] w_reg;
    logic       w_ctrl_wr;
    logic       w_arm;
    logic       w_lock_wr;
    logic       w_armed;
    logic       w_apply;
    logic       w_unused;

    assign w_sel     = romsel && (cpu_addr_in[14:12] == 3'b101);
    assign w_wr      = w_sel && !cpu_rw_in && !r_locked;
    assign w_reg     = cpu_addr_in[2:0];
    assign w_ctrl_wr = w_wr && (w_reg == 3'd6);
    assign w_arm     = w_ctrl_wr && cpu_data_in[0];
    assign w_lock_wr = w_ctrl_wr && cpu_data_in[7];
    assign w_armed   = (r_state == c_st_armed);
    // A re-arm on the timeout edge reloads the counter instead of applying.
    assign w_apply   = w_armed && !w_arm && (!romsel || (r_count <= 8'd1));
    assign w_unused  = ^cpu_addr_in[11:3];

    always_ff @(posedge m2) begin
        if (reset) begin
            r_state        <= c_st_idle;
            r_count        <= 8'd0;
            r_lock_req     <= 1'b0;
            r_locked       <= 1'b0;
            r_sh_base      <= '0;
            r_sh_prg_mask  <= c_prg_mask_rst;
            r_sh_chr_mask  <= '0;
            r_sh_mapper    <= '0;
            r_sh_ctrl      <= '0;
            r_act_base     <= '0;
            r_act_prg_mask <= c_prg_mask_rst;
            r_act_chr_mask <= '0;
            r_act_mapper   <= '0;
            r_act_ctrl     <= '0;
        end else begin
            if (w_wr) begin
                case (w_reg)
                    3'd0:    r_sh_base[12:8] <= cpu_data_in[4:0];
                    3'd1:    r_sh_base[7:0]  <= cpu_data_in;
                    3'd2:    r_sh_prg_mask   <= cpu_data_in[6:0];
                    3'd3:    r_sh_chr_mask   <= cpu_data_in[4:0];
                    3'd4:    r_sh_mapper     <= cpu_data_in[MAPPER_BITS-1:0];
                    3'd5:    r_sh_ctrl       <= cpu_data_in[6:0];
                    default: ;
                endcase
            end

            if (w_lock_wr) begin
                r_lock_req <= 1'b1;
            end

            if (w_arm) begin
                r_state <= c_st_armed;
                r_count <= c_timeout;
            end else if (w_apply) begin
                // Non-blocking copy takes the pre-write shadow on a collision.
                r_state        <= c_st_idle;
                r_count        <= 8'd0;
                r_act_base     <= r_sh_base;
                r_act_prg_mask <= r_sh_prg_mask;
                r_act_chr_mask <= r_sh_chr_mask;
                r_act_mapper   <= r_sh_mapper;
                r_act_ctrl     <= r_sh_ctrl;
                if (r_lock_req || w_lock_wr) begin
                    r_locked <= 1'b1;
                end
            end else if (w_armed && (r_count != 8'd0)) begin
                r_count <= r_count - 8'd1;
            end

            if (w_lock_wr && !w_armed && !w_arm) begin
                r_locked <= 1'b1;
            end
        end
    end

    assign cpu_base          = r_act_base;
    assign prg_mask          = r_act_prg_mask;
    assign chr_mask          = r_act_chr_mask;
    assign mapper            = r_act_mapper;
    assign sram_page         = r_act_ctrl[1:0];
    assign sram_enabled      = r_act_ctrl[2];
    assign chr_write_enabled = r_act_ctrl[3];
    assign prg_write_enabled = r_act_ctrl[4];
    assign map_rom_on_6000   = r_act_ctrl[5];
    assign four_screen       = r_act_ctrl[6];
    assign locked            = r_locked;
    assign commit_pending    = w_armed;

`ifdef COOLGIRL_CFG_READBACK_EN
    logic       w_rd;
    logic [7:0] w_rd_data;

    assign w_rd = w_sel && cpu_rw_in;

    always_comb begin
        w_rd_data = 8'h00;
        case (w_reg)
            3'd0:    w_rd_data = {3'b000, r_sh_base[12:8]};
            3'd1:    w_rd_data = r_sh_base[7:0];
            3'd2:    w_rd_data = {1'b0, r_sh_prg_mask};
            3'd3:    w_rd_data = {3'b000, r_sh_chr_mask};
            3'd4:    w_rd_data = 8'(r_sh_mapper);
            3'd5:    w_rd_data = {1'b0, r_sh_ctrl};
            3'd6:    w_rd_data = {r_locked, 6'b000000, w_armed};
            default: w_rd_data = 8'h00;
        endcase
    end

    assign cpu_data_out         = w_rd ? w_rd_data : 8'h00;
    assign cpu_data_out_enabled = w_rd;
`endif

endmodule

`default_nettype wire

// File: tb/tb_coolgirl_config_ctrl.sv
// Bench for coolgirl_config_ctrl: register-file model with deadline-based
// commit, compared on every falling edge, plus literal pin-down checks.
`default_nettype none

module tb_coolgirl_config_ctrl;

    localparam int T  = 4;
    localparam int MB = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        romsel = 1'b1;
    logic        rw = 1'b1;
    logic [14:0] addr = 15'h0;
    logic [7:0]  din = 8'h0;

    logic [12:0]   cpu_base;
    logic [6:0]    prg_mask;
    logic [4:0]    chr_mask;
    logic [MB-1:0] mapper;
    logic [1:0]    sram_page;
    logic sram_enabled, chr_write_enabled, prg_write_enabled;
    logic map_rom_on_6000, four_screen, locked, commit_pending;
`ifdef COOLGIRL_CFG_READBACK_EN
    logic [7:0] cpu_data_out;
    logic       cpu_data_out_enabled;
`endif

    coolgirl_config_ctrl #(.MAPPER_BITS(MB), .COMMIT_TIMEOUT(T)) dut (
        .m2(clk), .reset(reset), .romsel(romsel), .cpu_rw_in(rw),
        .cpu_addr_in(addr), .cpu_data_in(din),
        .cpu_base(cpu_base), .prg_mask(prg_mask), .chr_mask(chr_mask),
        .mapper(mapper), .sram_page(sram_page), .sram_enabled(sram_enabled),
        .chr_write_enabled(chr_write_enabled),
        .prg_write_enabled(prg_write_enabled),
        .map_rom_on_6000(map_rom_on_6000), .four_screen(four_screen),
        .locked(locked), .commit_pending(commit_pending)
`ifdef COOLGIRL_CFG_READBACK_EN
        ,
        .cpu_data_out(cpu_data_out),
        .cpu_data_out_enabled(cpu_data_out_enabled)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit started = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: register file view of shadow/active; commit has an absolute deadline edge.
    logic [7:0] m_sh  [0:5];
    logic [7:0] m_act [0:5];
    logic       m_armed = 1'b0, m_lock_req = 1'b0, m_locked = 1'b0;
    int         n_edge = 0;
    int         m_deadline = 0;

    function automatic logic [7:0] keep(input logic [2:0] r);
        case (r)
            3'd0, 3'd3, 3'd4: keep = 8'h1F;
            3'd2, 3'd5:       keep = 8'h7F;
            default:          keep = 8'hFF;
        endcase
    endfunction

    wire       m_acc   = romsel && (addr[14:12] == 3'b101);
    wire       m_wr    = m_acc && !rw && !m_locked;
    wire [2:0] m_r     = addr[2:0];
    wire       m_arm   = m_wr && (m_r == 3'd6) && din[0];
    wire       m_lockw = m_wr && (m_r == 3'd6) && din[7];
    wire       m_fire  = m_armed && !m_arm && (!romsel || (n_edge == m_deadline));

    always @(posedge clk) begin
        n_edge <= n_edge + 1;
        if (reset) begin
            for (int i = 0; i < 6; i++) begin
                m_sh[i]  <= (i == 2) ? 8'h7E : 8'h00;
                m_act[i] <= (i == 2) ? 8'h7E : 8'h00;
            end
            m_armed <= 1'b0; m_lock_req <= 1'b0; m_locked <= 1'b0;
        end else begin
            if (m_wr && (m_r < 3'd6)) m_sh[m_r] <= din & keep(m_r);
            if (m_lockw) m_lock_req <= 1'b1;
            if (m_arm) begin
                m_armed    <= 1'b1;
                m_deadline <= n_edge + T;
            end else if (m_fire) begin
                m_armed <= 1'b0;
                for (int i = 0; i < 6; i++) m_act[i] <= m_sh[i];
                if (m_lock_req || m_lockw) m_locked <= 1'b1;
            end
            if (m_lockw && !m_armed && !m_arm) m_locked <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("cpu_base", cpu_base, {m_act[0][4:0], m_act[1]});
            chk("prg_mask", prg_mask, m_act[2][6:0]);
            chk("chr_mask", chr_mask, m_act[3][4:0]);
            chk("mapper", mapper, m_act[4][MB-1:0]);
            chk("ctrl", {four_screen, map_rom_on_6000, prg_write_enabled,
                         chr_write_enabled, sram_enabled, sram_page}, m_act[5][6:0]);
            chk("locked", locked, m_locked);
            chk("commit_pending", commit_pending, m_armed);
`ifdef COOLGIRL_CFG_READBACK_EN
            chk("rd_oe", cpu_data_out_enabled, m_acc && rw);
            chk("rd_data", cpu_data_out,
                !(m_acc && rw) ? 8'h00 :
                (m_r < 3'd6)   ? m_sh[m_r] :
                (m_r == 3'd6)  ? {m_locked, 6'b0, m_armed} : 8'h00);
`endif
        end
    end

    // One bus cycle: drive, let the next rising edge sample it, return idle.
    task automatic op(input logic rs, input logic r_w, input logic [14:0] a, input logic [7:0] d);
        romsel = rs; rw = r_w; addr = a; din = d;
        @(posedge clk); #1;
        romsel = 1'b1; rw = 1'b1; addr = 15'h0; din = 8'h0;
    endtask

    task automatic wr(input logic [2:0] r, input logic [7:0] d);
        op(1'b1, 1'b0, {3'b101, 9'h0, r}, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) op(1'b1, 1'b1, 15'h0, 8'h0);
    endtask

    task automatic rom_fetch();
        op(1'b0, 1'b1, 15'h0123, 8'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1; idle(2); reset = 1'b0;
    endtask

    initial begin
        do_reset();
        started = 1'b1;
        chk("rst cpu_base", cpu_base, 0);
        chk("rst prg_mask", prg_mask, 7'h7E);
        chk("rst mapper", mapper, 0);
        chk("rst locked", locked, 0);
        chk("rst pending", commit_pending, 0);

        // Commit on ROM fetch
        wr(3'd1, 8'h2A); wr(3'd4, 8'h04); wr(3'd6, 8'h01);
        chk("arm pending", commit_pending, 1);
        idle(1);
        chk("pre-apply mapper", mapper, 0);
        rom_fetch();
        chk("apply base", cpu_base, 13'h002A);
        chk("apply mapper", mapper, 4);
        chk("apply pending", commit_pending, 0);

        // Timeout apply on exactly the T-th edge
        wr(3'd4, 8'h09); wr(3'd6, 8'h01);
        idle(T - 1);
        chk("to pending k+3", commit_pending, 1);
        chk("to mapper k+3", mapper, 4);
        idle(1);
        chk("to pending k+4", commit_pending, 0);
        chk("to mapper k+4", mapper, 9);

        // Shadow write on the apply edge
        wr(3'd4, 8'h0B); wr(3'd6, 8'h01);
        idle(T - 1);
        wr(3'd4, 8'h0C);
        chk("collide mapper", mapper, 8'h0B);
        wr(3'd6, 8'h01); rom_fetch();
        chk("collide later", mapper, 8'h0C);

        // Re-arm reloads the countdown
        wr(3'd4, 8'h11); wr(3'd6, 8'h01);
        idle(2);
        wr(3'd6, 8'h01);
        idle(T - 1);
        chk("rearm pending", commit_pending, 1);
        idle(1);
        chk("rearm applied", mapper, 8'h11);

        // Remaining fields; non-register writes ignored
        wr(3'd0, 8'hFF); wr(3'd2, 8'h95); wr(3'd3, 8'h0A); wr(3'd5, 8'hFF); wr(3'd7, 8'hAA);
        op(1'b1, 1'b0, 15'h4006, 8'h01);
        op(1'b0, 1'b0, 15'h5006, 8'h01);
        chk("stray pending", commit_pending, 0);
        wr(3'd6, 8'h01); rom_fetch();
        chk("f base", cpu_base, 13'h1F2A);
        chk("f prg_mask", prg_mask, 7'h15);
        chk("f chr_mask", chr_mask, 5'h0A);
        chk("f four_screen", four_screen, 1);
        chk("f sram_page", sram_page, 2'd3);

        // Reset while armed discards the commit
        wr(3'd4, 8'h03); wr(3'd6, 8'h01);
        reset = 1'b1; idle(1); reset = 1'b0;
        rom_fetch();
        chk("midrst mapper", mapper, 0);
        chk("midrst base", cpu_base, 0);
        chk("midrst prg_mask", prg_mask, 7'h7E);
        chk("midrst pending", commit_pending, 0);

        // Lock together with commit, then writes are ignored
        wr(3'd4, 8'h05); wr(3'd6, 8'h81);
        chk("lockarm locked", locked, 0);
        rom_fetch();
        chk("lock locked", locked, 1);
        chk("lock mapper", mapper, 5);
        wr(3'd4, 8'h07); wr(3'd6, 8'h01); rom_fetch(); rom_fetch();
        chk("locked mapper", mapper, 5);
        chk("locked pending", commit_pending, 0);

        // Immediate lock from IDLE
        do_reset();
        wr(3'd6, 8'h80);
        chk("imm locked", locked, 1);
        chk("imm pending", commit_pending, 0);
        do_reset();

`ifdef COOLGIRL_CFG_READBACK_EN
        wr(3'd3, 8'h1F);
        romsel = 1'b1; rw = 1'b1; addr = 15'h5003; #2;
        chk("rb data 3", cpu_data_out, 8'h1F);
        chk("rb oe 3", cpu_data_out_enabled, 1);
        idle(1);
        romsel = 1'b1; rw = 1'b1; addr = 15'h5007; #2;
        chk("rb data 7", cpu_data_out, 8'h00);
        chk("rb oe 7", cpu_data_out_enabled, 1);
        idle(1);
        wr(3'd6, 8'h01);
        romsel = 1'b1; rw = 1'b1; addr = 15'h5006; #2;
        chk("rb data 6", cpu_data_out, 8'h01);
        idle(T);
`endif

        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
